uart_apb_sequencer: RTL and testbench

APB master that sequences the UART's register interface on PCLK. After reset it programs the baud divisors, line control and control registers. It then polls the flag register and moves bytes between a byte-stream client and the UART data register. Transmit and receive requests share the single APB port through a round-robin arbiter.

---
 rtl/uart_apb_sequencer.sv | 176 +++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB master that configures a UART and then moves bytes
// between a tx/rx byte-stream client and the UART data register.
// Ports: PCLK/PRESET (sync, active-high); APB master PSEL/PENABLE/PWRITE/PADDR/
// PWDATA/PRDATA; tx_data/tx_valid/tx_ready in; rx_data/rx_err/rx_valid/rx_ready
// out; init_done high once the four config writes have completed.
module uart_apb_sequencer #(
  parameter logic [15:0] BAUD_DIVINT  = 16'd27,
  parameter logic [5:0]  BAUD_DIVFRAC = 6'd8,
  parameter logic [15:0] LCR_H_VAL    = 16'h0070,
  parameter logic [15:0] CR_VAL       = 16'h0301
) (
  input  logic        PCLK,
  input  logic        PRESET,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [11:0] PADDR,
  output logic [15:0] PWDATA,
  input  logic [15:0] PRDATA,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic [3:0]  rx_err,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        init_done
);

  typedef enum logic [2:0] {
    INIT_IBRD,
    INIT_FBRD,
    INIT_LCRH,
    INIT_CR,
    POLL_FR,
    DECIDE,
    WR_DR,
    RD_DR
  } state_t;

  state_t r_state;
  logic   r_boot;
  logic   r_last_tx;
  logic   r_txff;
  logic   r_rxfe;

  logic        w_rx_req;
  logic        w_tx_req;
  logic        w_pick_rx;
  logic        w_go;
  state_t      w_tgt;
  logic        w_write;
  logic [11:0] w_addr;
  logic [15:0] w_wdata;
  logic        w_unused_prdata;

  assign w_unused_prdata = ^PRDATA[15:12];

  assign w_rx_req  = !r_rxfe && !rx_valid;
  assign w_tx_req  = tx_valid && !r_txff;
  // On a conflict, rx wins if tx had the last contested grant.
  assign w_pick_rx = w_rx_req && (!w_tx_req || r_last_tx);

  // Next transfer to set up; w_go=0 means the bus idles in DECIDE.
  always_comb begin
    w_go  = 1'b1;
    w_tgt = r_state;
    if (r_state == DECIDE) begin
      if (w_pick_rx)     w_tgt = RD_DR;
      else if (w_tx_req) w_tgt = WR_DR;
      else               w_tgt = POLL_FR;
    end else if (PENABLE) begin
      unique case (r_state)
        INIT_IBRD: w_tgt = INIT_FBRD;
        INIT_FBRD: w_tgt = INIT_LCRH;
        INIT_LCRH: w_tgt = INIT_CR;
        POLL_FR: begin
          w_tgt = DECIDE;
          w_go  = 1'b0;
        end
        default:   w_tgt = POLL_FR;
      endcase
    end
  end

  always_comb begin
    w_write = 1'b0;
    w_addr  = 12'h000;
    w_wdata = 16'h0000;
    unique case (w_tgt)
      INIT_IBRD: begin
        w_write = 1'b1;
        w_addr  = 12'h024;
        w_wdata = BAUD_DIVINT;
      end
      INIT_FBRD: begin
        w_write = 1'b1;
        w_addr  = 12'h028;
        w_wdata = {10'd0, BAUD_DIVFRAC};
      end
      INIT_LCRH: begin
        w_write = 1'b1;
        w_addr  = 12'h02C;
        w_wdata = LCR_H_VAL;
      end
      INIT_CR: begin
        w_write = 1'b1;
        w_addr  = 12'h030;
        w_wdata = CR_VAL;
      end
      POLL_FR: w_addr = 12'h018;
      WR_DR: begin
        w_write = 1'b1;
        w_wdata = {8'h00, tx_data};
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= INIT_IBRD;
      r_boot    <= 1'b0;
      r_last_tx <= 1'b1;
      r_txff    <= 1'b1;
      r_rxfe    <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 12'h000;
      PWDATA    <= 16'h0000;
      tx_ready  <= 1'b0;
      rx_data   <= 8'h00;
      rx_err    <= 4'h0;
      rx_valid  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      // One settle cycle after reset release before the first SETUP.
      if (!r_boot) begin
        r_boot <= 1'b1;
      end else if (PSEL && !PENABLE) begin
        PENABLE  <= 1'b1;
        tx_ready <= (r_state == WR_DR);
      end else begin
        if (PENABLE) begin
          case (r_state)
            POLL_FR: begin
              r_txff <= PRDATA[5];
              r_rxfe <= PRDATA[4];
            end
            RD_DR: begin
              rx_data  <= PRDATA[7:0];
              rx_err   <= PRDATA[11:8];
              rx_valid <= 1'b1;
            end
            INIT_CR: init_done <= 1'b1;
            default: ;
          endcase
        end
        if (r_state == DECIDE && w_rx_req && w_tx_req)
          r_last_tx <= !r_last_tx;
        r_state <= w_tgt;
        PSEL    <= w_go;
        PENABLE <= 1'b0;
        if (w_go) begin
          PWRITE <= w_write;
          PADDR  <= w_addr;
          PWDATA <= w_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb_uart_apb_sequencer: directed bench for uart_apb_sequencer.
// UART register model answers FR/DR reads from bench variables.
module tb_uart_apb_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL, PENABLE, PWRITE;
  logic [11:0] PADDR;
  logic [15:0] PWDATA, PRDATA;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic [3:0]  rx_err;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        init_done;

  logic [15:0] fr = 16'h0010;
  logic [15:0] dr = 16'h0000;

  always #5 PCLK = ~PCLK;

  assign PRDATA = (PADDR == 12'h018) ? fr :
                  (PADDR == 12'h000) ? dr : 16'h0000;

  uart_apb_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .init_done(init_done)
  );

  typedef struct {
    logic [15:0] fr_in;
    logic        psel;
    logic        pen;
    logic        pwr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        idone;
  } vec_t;

  vec_t vecs[13];

  int n_err = 0;
  int n_chk = 0;
  int n_txr = 0;
  logic [28:0] log_q[$];

  function automatic vec_t mk(logic [15:0] f, logic s, logic e, logic w,
                              logic [11:0] a, logic [15:0] d, logic i);
    vec_t v;
    v.fr_in = f; v.psel = s; v.pen = e; v.pwr = w;
    v.addr = a; v.wdata = d; v.idone = i;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Step one clock and sample 1ns after the edge; record completed transfers.
  task automatic tick();
    @(posedge PCLK);
    #1;
    if (PSEL && PENABLE)
      log_q.push_back({PWRITE, PADDR, PWRITE ? PWDATA : 16'h0000});
    if (tx_ready) n_txr++;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    fr = 16'h0010;
    dr = 16'h0000;
    tick();
    tick();
    PRESET = 1'b0;
    log_q.delete();
    n_txr = 0;
  endtask

  function automatic int count_dr(logic wr);
    int c = 0;
    foreach (log_q[i])
      if (log_q[i][27:16] == 12'h000 && log_q[i][28] == wr) c++;
    return c;
  endfunction

  function automatic int count_fr();
    int c = 0;
    foreach (log_q[i])
      if (log_q[i][27:16] == 12'h018 && !log_q[i][28]) c++;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int idx;
    logic held;
    logic [5:0] pat;
    logic [31:0] act, exp;

    vecs[0]  = mk(16'h0010, 0, 0, 0, 12'h000, 16'h0000, 0);
    vecs[1]  = mk(16'h0010, 1, 0, 1, 12'h024, 16'h001B, 0);
    vecs[2]  = mk(16'h0010, 1, 1, 1, 12'h024, 16'h001B, 0);
    vecs[3]  = mk(16'h0010, 1, 0, 1, 12'h028, 16'h0008, 0);
    vecs[4]  = mk(16'h0010, 1, 1, 1, 12'h028, 16'h0008, 0);
    vecs[5]  = mk(16'h0010, 1, 0, 1, 12'h02C, 16'h0070, 0);
    vecs[6]  = mk(16'h0010, 1, 1, 1, 12'h02C, 16'h0070, 0);
    vecs[7]  = mk(16'h0010, 1, 0, 1, 12'h030, 16'h0301, 0);
    vecs[8]  = mk(16'h0010, 1, 1, 1, 12'h030, 16'h0301, 0);
    vecs[9]  = mk(16'h0010, 1, 0, 0, 12'h018, 16'h0000, 1);
    vecs[10] = mk(16'h0010, 1, 1, 0, 12'h018, 16'h0000, 1);
    vecs[11] = mk(16'h0010, 0, 0, 0, 12'h018, 16'h0000, 1);
    vecs[12] = mk(16'h0010, 1, 0, 0, 12'h018, 16'h0000, 1);

    // Reset values
    do_reset();
    act = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_ready};
    check("reset_bus", act, 32'h0);
    check("reset_rx", {rx_valid, rx_data, rx_err, init_done}, 32'h0);

    // Init sequence and first idle poll, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      fr = vecs[i].fr_in;
      tick();
      act = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, init_done};
      exp = {vecs[i].psel, vecs[i].pen, vecs[i].pwr,
             vecs[i].addr, vecs[i].wdata, vecs[i].idone};
      check($sformatf("init_c%0d", i), act, exp);
    end

    // Single tx: raised during POLL SETUP, tx_ready 4 cycles later
    fr = 16'h0090;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 10) begin tick(); n++; end
    check("tx_latency", n, 4);
    check("tx_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
          {3'b111, 12'h000, 16'h00A5});
    tick();
    tx_valid = 1'b0;
    repeat (8) tick();
    check("tx_dr_writes", count_dr(1'b1), 1);
    check("tx_ready_pulses", n_txr, 1);
    idx = -1;
    foreach (log_q[i]) if (log_q[i] == {1'b1, 12'h000, 16'h00A5}) idx = i;
    if (idx >= 0 && idx + 1 < log_q.size())
      check("tx_then_poll", log_q[idx+1], {1'b0, 12'h018, 16'h0000});
    else
      check("tx_then_poll_found", idx + 1 < log_q.size() && idx >= 0, 1);

    // TX FIFO full for 10 polls, then released
    do_reset();
    repeat (13) tick();
    log_q.delete();
    fr = 16'h0030;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    repeat (30) tick();
    check("full_polls", count_fr(), 10);
    check("full_no_dr", count_dr(1'b1) + count_dr(1'b0), 0);
    check("full_no_ready", n_txr, 0);
    fr = 16'h0010;
    n = 0;
    while (!tx_ready && n < 10) begin tick(); n++; end
    check("full_release_lat", n, 4);
    check("full_release_data", {PWRITE, PADDR, PWDATA},
          {1'b1, 12'h000, 16'h003C});
    tick();
    tx_valid = 1'b0;

    // RX with error bits and backpressure
    do_reset();
    repeat (13) tick();
    log_q.delete();
    fr = 16'h0000;
    dr = 16'h0442;
    n = 0;
    while (!rx_valid && n < 12) begin tick(); n++; end
    check("rx_first_valid", rx_valid, 1);
    check("rx_first_data", rx_data, 8'h42);
    check("rx_first_err", rx_err, 4'b0100);
    held = 1'b1;
    repeat (20) begin
      tick();
      if (!rx_valid) held = 1'b0;
    end
    check("rx_held", held, 1);
    check("rx_no_reread", count_dr(1'b0), 1);
    dr = 16'h0081;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx_cleared", rx_valid, 0);
    n = 0;
    while (!rx_valid && n < 12) begin tick(); n++; end
    check("rx_second_valid", rx_valid, 1);
    check("rx_second_data", {rx_err, rx_data}, 12'h081);
    check("rx_second_reads", count_dr(1'b0), 2);

    // Arbitration: both sides pending continuously
    do_reset();
    repeat (13) tick();
    log_q.delete();
    fr = 16'h0000;
    dr = 16'h0011;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    rx_ready = 1'b1;
    n = 0;
    while ((count_dr(1'b0) + count_dr(1'b1)) < 6 && n < 60) begin
      tick(); n++;
    end
    pat = '0;
    idx = 0;
    foreach (log_q[i])
      if (log_q[i][27:16] == 12'h000 && idx < 6) begin
        pat[idx] = log_q[i][28];
        idx++;
      end
    check("arb_count", idx, 6);
    check("arb_order", pat, 6'b101010);
    tx_valid = 1'b0;
    rx_ready = 1'b0;

    // Reset during WR_DR SETUP
    do_reset();
    repeat (13) tick();
    fr = 16'h0090;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    n = 0;
    while (!(PSEL && !PENABLE && PWRITE && PADDR == 12'h000) && n < 20) begin
      tick(); n++;
    end
    check("rst_wr_setup_seen", PSEL && !PENABLE && PWRITE && PADDR == 12'h000, 1);
    PRESET = 1'b1;
    tick();
    check("rst_psel", {PSEL, PENABLE, tx_ready, init_done}, 4'b0000);
    PRESET = 1'b0;
    tx_valid = 1'b0;
    log_q.delete();
    repeat (13) tick();
    check("rst_no_ready", n_txr, 0);
    check("rst_log_size", log_q.size(), 5);
    if (log_q.size() >= 4) begin
      check("rst_first_write", log_q[0], {1'b1, 12'h024, 16'h001B});
      check("rst_cr_write", log_q[3], {1'b1, 12'h030, 16'h0301});
    end
    check("rst_no_dr", count_dr(1'b1), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
